instruction_fetch_sequencer: RTL and testbench
==============================================

Name: instruction_fetch_sequencer

Overview:
Owns the program counter and drives the combinational program-memory ROM: one word fetched per cycle, address presented on Mem_Address_o, instruction returned same cycle on Mem_Instruction_i.
Fetched {PC, instruction} pairs are buffered in a small FIFO and handed to decode over a valid/ready handshake.
Supports halt (fetch enable) and flush/redirect from branch/jump resolution.
Sits between the program memory and the decode stage of the pipelined core.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction
RESET_PC, 32'h0040_0000, PC value after reset (text segment base)
QUEUE_DEPTH, 4, fetch-queue entries; power of two, 2..16

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
Fetch_Enable_i  input  1  1 = fetch one word per cycle when queue has room
Flush_i  input  1  discard queue, redirect PC to Target_i
Target_i  input  DATA_WIDTH  redirect address, sampled when Flush_i=1
Mem_Address_o  output  DATA_WIDTH  byte address to program memory (= PC register)
Mem_Instruction_i  input  DATA_WIDTH  ROM read data for Mem_Address_o, same cycle
Valid_o  input/output: output  1  queue head holds a valid instruction
Ready_i  input  1  decode accepts head this cycle
Instruction_o  output  DATA_WIDTH  head instruction; 0 when Valid_o=0
PC_o  output  DATA_WIDTH  PC of head instruction; 0 when Valid_o=0
Count_o  output  log2(QUEUE_DEPTH)+1  occupied entries

Behaviour:
- Reset (async, any time incl. mid-flush): PC=RESET_PC, rd/wr pointers=0, Count_o=0, Valid_o=0, Instruction_o=0, PC_o=0. Mem_Address_o=RESET_PC.
- Mem_Address_o is PC register directly; no combinational path from Ready_i/Flush_i to Mem_Address_o.
- pop = Valid_o & Ready_i & ~Flush_i.
- push = Fetch_Enable_i & ~Flush_i & (Count_o < QUEUE_DEPTH | pop). Full queue with simultaneous pop still pushes (full throughput).
- On push: entry[wr] <= {PC, Mem_Instruction_i}; wr++ (wraps mod QUEUE_DEPTH); PC <= PC + 4 (wraps mod 2^DATA_WIDTH, 32'hFFFF_FFFC -> 0).
- On pop: rd++ (wraps). Count_o += push - pop.
- Latency: word at PC X fetched in cycle n appears at head (Valid_o=1) in cycle n+1 when queue was empty; no bypass from memory to output.
- Empty and push-same-cycle: Valid_o stays 0 this cycle, 1 next.
- Flush_i=1: overrides push and pop; next cycle Count_o=0, pointers=0, Valid_o=0, PC <= {Target_i[DATA_WIDTH-1:2], 2'b00} (misaligned targets force-aligned). Fetch from target begins the cycle after flush.
- Back-to-back flushes: last Target_i wins; nothing pushed until Flush_i drops.
- Fetch_Enable_i=0: PC holds, no push; queue continues to drain.
- Valid_o=0 with Ready_i=1: no effect.
- Head outputs come from registered queue storage plus Count_o != 0; they are stable while Valid_o=1 and Ready_i=0.

Decomposition:
- Shared package: RESET_PC default, instruction width, PC increment (4), NOP encoding 32'h0000_0013 for downstream bubble insertion.
- One sub-module: fetch_queue (parameterised synchronous FIFO, DATA_WIDTH*2 wide, push/pop/clear, count, async reset). Sequencer holds PC, push/pop/flush logic.

Test Plan:
- Reset release, Fetch_Enable_i=1, Ready_i=1, ROM word i = i+1 -> Mem_Address_o 0x00400000,0x00400004,...; cycle 1 on, Valid_o=1, PC_o/Instruction_o = (0x00400000,1),(0x00400004,2)... one per cycle.
- Ready_i=0 for 6 cycles -> Count_o climbs to 4, PC stops at 0x00400010, head stays (0x00400000,1); Ready_i=1 -> drains in order, no drop or duplicate.
- Queue full, Ready_i=1 -> push and pop same cycle, Count_o stays 4, PC advances by 4 each cycle.
- Count_o=3, Flush_i=1, Target_i=0x00400046 -> next cycle Count_o=0, Valid_o=0, Mem_Address_o=0x00400044; following cycle head PC_o=0x00400044.
- PC set by flush to 0xFFFFFFFC, run 2 fetches -> PC_o 0xFFFFFFFC then 0x00000000.
- reset asserted mid-stream between clock edges with Count_o=2 -> outputs immediately Valid_o=0, Count_o=0, Mem_Address_o=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared constants and types for the instruction fetch sequencer and its fetch queue.
// Holds the reset PC default, instruction width, PC increment and the NOP encoding.
package instruction_fetch_sequencer_pkg;

   localparam int          INSTR_WIDTH      = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
   localparam logic [31:0] PC_INCREMENT     = 32'h0000_0004;
   // Bubble encoding (addi x0,x0,0) for stages downstream of decode.
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   typedef enum logic [1:0] {
      QOP_HOLD = 2'b00,
      QOP_POP  = 2'b01,
      QOP_PUSH = 2'b10,
      QOP_BOTH = 2'b11
   } queue_op_t;

endpackage

// File: rtl/instruction_fetch_sequencer_fetch_queue.sv
// Synchronous FIFO of fetched {PC, instruction} pairs with push, pop, clear and occupancy.
// DEPTH must be a power of two so pointer wrap is a natural binary overflow.
module instruction_fetch_sequencer_fetch_queue
   import instruction_fetch_sequencer_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   queue_op_t        op;

   always_comb begin
      op = queue_op_t'({push, pop});
   end

   // A full queue with a simultaneous pop overwrites the slot being read out this cycle.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= {PTR_W{1'b0}};
         rd_ptr <= {PTR_W{1'b0}};
         cnt    <= {CNT_W{1'b0}};
      end else if (clear) begin
         wr_ptr <= {PTR_W{1'b0}};
         rd_ptr <= {PTR_W{1'b0}};
         cnt    <= {CNT_W{1'b0}};
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case (op)
            QOP_PUSH: cnt <= cnt + CNT_W'(1);
            QOP_POP:  cnt <= cnt - CNT_W'(1);
            QOP_HOLD: cnt <= cnt;
            QOP_BOTH: cnt <= cnt;
            default:  cnt <= cnt;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign count   = cnt;

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Program counter owner: fetches one ROM word per cycle into a small queue feeding decode.
// Supports halt via Fetch_Enable_i and flush/redirect from branch resolution.
module instruction_fetch_sequencer
   import instruction_fetch_sequencer_pkg::*;
#(
   parameter int                    DATA_WIDTH  = INSTR_WIDTH,
   parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(DEFAULT_RESET_PC),
   parameter int                    QUEUE_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          Fetch_Enable_i,
   input  logic                          Flush_i,
   input  logic [DATA_WIDTH-1:0]         Target_i,
   output logic [DATA_WIDTH-1:0]         Mem_Address_o,
   input  logic [DATA_WIDTH-1:0]         Mem_Instruction_i,
   output logic                          Valid_o,
   input  logic                          Ready_i,
   output logic [DATA_WIDTH-1:0]         Instruction_o,
   output logic [DATA_WIDTH-1:0]         PC_o,
   output logic [$clog2(QUEUE_DEPTH):0]  Count_o
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   logic [DATA_WIDTH-1:0]   pc;
   logic [DATA_WIDTH-1:0]   next_pc;
   logic [DATA_WIDTH-1:0]   aligned_target;
   logic [2*DATA_WIDTH-1:0] head;
   logic [CNT_W-1:0]        count;
   logic                    valid;
   logic                    push;
   logic                    pop;

   assign valid = (count != {CNT_W{1'b0}});

   always_comb begin
      pop  = valid & Ready_i & ~Flush_i;
      push = Fetch_Enable_i & ~Flush_i & ((count < CNT_W'(QUEUE_DEPTH)) | pop);
   end

   // Redirect targets are forced to word alignment by clearing the low two bits.
   always_comb begin
      aligned_target = Target_i & ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
      if (Flush_i) begin
         next_pc = aligned_target;
      end else if (push) begin
         next_pc = pc + DATA_WIDTH'(PC_INCREMENT);
      end else begin
         next_pc = pc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= next_pc;
      end
   end

   instruction_fetch_sequencer_fetch_queue #(
      .WIDTH (2*DATA_WIDTH),
      .DEPTH (QUEUE_DEPTH)
   ) u_fetch_queue (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .clear   (Flush_i),
      .wr_data ({pc, Mem_Instruction_i}),
      .rd_data (head),
      .count   (count)
   );

   // Head fields are gated to zero while the queue is empty.
   always_comb begin
      if (valid) begin
         PC_o          = head[2*DATA_WIDTH-1:DATA_WIDTH];
         Instruction_o = head[DATA_WIDTH-1:0];
      end else begin
         PC_o          = {DATA_WIDTH{1'b0}};
         Instruction_o = {DATA_WIDTH{1'b0}};
      end
   end

   assign Mem_Address_o = pc;
   assign Valid_o       = valid;
   assign Count_o       = count;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Scoreboard bench: stimulus pushes expected {PC, instruction} pairs; a monitor pops and compares.
// The reference model is a plain queue plus a PC and occupancy count.
module tb_instruction_fetch_sequencer;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam int          DEPTH  = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_enable = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] target = 32'h0;
   logic [31:0] mem_address;
   logic [31:0] mem_instruction;
   logic        valid;
   logic        ready = 1'b0;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic [2:0]  count;

   int          vectors = 0;
   int          miscompares = 0;

   logic [63:0] exp_q[$];
   int          model_count = 0;
   logic [31:0] model_pc = RST_PC;
   int          snap_count = 0;
   logic [31:0] snap_pc = RST_PC;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return ((a - RST_PC) >> 2) + 32'd1;
   endfunction

   assign mem_instruction = rom(mem_address);

   instruction_fetch_sequencer #(
      .DATA_WIDTH  (32),
      .RESET_PC    (RST_PC),
      .QUEUE_DEPTH (DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .Fetch_Enable_i    (fetch_enable),
      .Flush_i           (flush),
      .Target_i          (target),
      .Mem_Address_o     (mem_address),
      .Mem_Instruction_i (mem_instruction),
      .Valid_o           (valid),
      .Ready_i           (ready),
      .Instruction_o     (instruction),
      .PC_o              (pc_out),
      .Count_o           (count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: inputs change on the falling edge, model advances to post-edge state.
   task automatic drive(input logic fe, input logic fl, input logic [31:0] tgt, input logic rdy);
      logic pop_m;
      logic push_m;
      @(negedge clk);
      reset        = 1'b0;
      snap_count   = model_count;
      snap_pc      = model_pc;
      fetch_enable = fe;
      flush        = fl;
      target       = tgt;
      ready        = rdy;
      pop_m  = (model_count != 0) && rdy && !fl;
      push_m = fe && !fl && ((model_count < DEPTH) || pop_m);
      if (fl) begin
         exp_q.delete();
         model_count = 0;
         model_pc    = {tgt[31:2], 2'b00};
      end else begin
         if (push_m) begin
            exp_q.push_back({model_pc, rom(model_pc)});
            model_pc = model_pc + 32'd4;
         end
         model_count = model_count + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
      end
   endtask

   task automatic mid_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      check("rst_valid", {31'h0, valid}, 32'h0);
      check("rst_count", {29'h0, count}, 32'h0);
      check("rst_addr", mem_address, RST_PC);
      check("rst_head_pc", pc_out, 32'h0);
      exp_q.delete();
      model_count = 0;
      model_pc    = RST_PC;
      snap_count  = 0;
      snap_pc     = RST_PC;
   endtask

   // Monitor: compares occupancy, address and head against the model; pops on accepted handshakes.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         check("count", {29'h0, count}, snap_count[31:0]);
         check("mem_addr", mem_address, snap_pc);
         check("valid", {31'h0, valid}, {31'h0, (snap_count != 0)});
         if (!valid) begin
            check("idle_pc", pc_out, 32'h0);
            check("idle_instr", instruction, 32'h0);
         end else if (!flush) begin
            if (exp_q.size() == 0) begin
               check("sb_depth", 32'h0, 32'h1);
            end else begin
               check("head_pc", pc_out, exp_q[0][63:32]);
               check("head_instr", instruction, exp_q[0][31:0]);
               if (ready) begin
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      // Streaming from reset with decode always ready.
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
      // Flush to empty, then back-pressure until the queue fills.
      drive(1'b0, 1'b1, RST_PC, 1'b0);
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
      // Three entries queued, then a misaligned redirect.
      drive(1'b0, 1'b1, RST_PC, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b1, 32'h0040_0046, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
      // Back-to-back flushes, last one lands at the top of the address space.
      drive(1'b1, 1'b1, 32'h0000_1234, 1'b1);
      drive(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
      // Halted fetch drains the queue.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 32'h0, 1'b1);
      // Two entries queued, then reset between clock edges.
      drive(1'b0, 1'b1, 32'h0040_0100, 1'b0);
      for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);
      mid_reset();
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tgt;
         logic        fl;
         fl  = ($urandom_range(0, 24) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : (RST_PC + 32'($urandom_range(0, 255)));
         drive(($urandom_range(0, 7) != 0), fl, tgt, ($urandom_range(0, 2) != 0));
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      #4;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
